pixel_job_dispatcher: RTL and testbench
=======================================

Name: pixel_job_dispatcher

Overview:
Frame-level scheduler for the Mandelbrot processor array. It walks the screen in raster order and hands one pixel job (VGA address plus complex coordinate c) to an idle processor each cycle, with round-robin fairness. It counts pixel writes retired by the processor-to-memory arbiter and signals frame completion. It sits upstream of the processor array; the processors' results flow out through the existing processor-to-VGA-memory arbiter.

Parameters:
NUM_PROCS, 8, number of processors served (1..32)
H_RES, 640, pixels per line
V_RES, 480, lines per frame
FIX_W, 27, fixed-point width of coordinates (4.23 two's complement)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
iStart  in  1  single-cycle frame start request
iX0  in  FIX_W  real coordinate of pixel (0,0)
iY0  in  FIX_W  imaginary coordinate of pixel (0,0)
iDx  in  FIX_W  signed real step per pixel
iDy  in  FIX_W  signed imaginary step per line
iProcIdle  in  NUM_PROCS  per-processor idle/ready-for-job flag
iPixWritten  in  1  one pulse per pixel written to VGA memory (arbiter w_en)
oJobValid  out  NUM_PROCS  one-hot job strobe, 1 cycle
oJobAddr  out  19  VGA address = y*H_RES + x
oJobCre  out  FIX_W  real part of c
oJobCim  out  FIX_W  imaginary part of c
oBusy  out  1  high from accepted start until frame done
oFrameDone  out  1  one-cycle pulse when the last pixel is written

Behaviour:
- Reset (reset==0 at posedge): state IDLE. oJobValid=0, oJobAddr=0, oJobCre=0, oJobCim=0, oBusy=0, oFrameDone=0. x, y, issued and written counters are 0. RR pointer is 0. Reset mid-frame aborts with no done pulse.
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE: on iStart, latch iX0/iY0/iDx/iDy, set x=y=0, addr=0, cre=iX0, cim=iY0, clear counters, oBusy=1, go to DISPATCH.
- DISPATCH: each cycle, pick the first processor i with iProcIdle[i]=1 and not masked. Search starts at the index after the last grant and wraps modulo NUM_PROCS.
  - If one is found, the next cycle drives oJobValid[i]=1 together with the current addr/cre/cim. Registered outputs give 1-cycle latency from grant decision.
  - The granted processor is masked for the 2 cycles following its strobe, so a stale iProcIdle cannot re-grant it. Processors must drop iProcIdle within 2 cycles of the strobe.
  - At most one job is issued per cycle. If no processor is eligible, oJobValid=0 and no coordinate advances.
- Coordinate advance on each issue:
  - x<H_RES-1: x+1, addr+1, cre+=dx.
  - Else (line wrap): x=0, y+1, addr+1, cre=X0, cim+=dy.
  - All FIX_W sums wrap modulo 2^FIX_W with no saturation.
- After issuing pixel H_RES*V_RES-1: go to DRAIN; oJobValid=0 from then on.
- Written counter increments on every iPixWritten while in DISPATCH or DRAIN. Pulses in IDLE/DONE are ignored.
- DRAIN: when the written count reaches H_RES*V_RES, go to DONE. The same-cycle final write is counted before the compare.
- DONE: oFrameDone=1 for exactly one cycle, oBusy=0, return to IDLE.
- iStart is ignored when not in IDLE; iStart in DONE is also ignored.
- Simultaneous issue and write in one cycle: both counters update independently.
- Written count exceeding the issued count is a protocol error and is not checked.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles with iProcIdle=all-1 -> all outputs 0, no oJobValid. Release reset with no iStart -> outputs stay 0.
- Raster and coordinates: H_RES=4, V_RES=2, NUM_PROCS=4, X0=0x100, Y0=0x200, dx=0x10, dy=-0x8, all idle.
  - Job order must be 0..7.
  - Required cre sequence: 0x100, 0x110, 0x120, 0x130, 0x100, 0x110, 0x120, 0x130.
  - Required cim: 0x200 for jobs 0-3, 0x1F8 for jobs 4-7.
- Round-robin and mask: all procs idle and never dropping -> grants cycle 0,1,2,3,0 with no processor granted twice within 3 cycles. Only proc 2 idle -> grants to proc 2 are spaced at least 3 cycles apart.
- Frame completion: after all 8 issues, supply 7 iPixWritten pulses -> oBusy=1, no done. The 8th pulse -> oFrameDone high for exactly 1 cycle, then IDLE with oBusy=0.
- Start while busy: iStart during DISPATCH -> ignored; job sequence and counts unchanged.
- Reset mid-frame: assert reset after 3 issues -> next cycle all outputs 0. A new iStart restarts at addr 0 with cre=X0.

Source files
------------

// File: rtl/pixel_job_dispatcher.sv
// Raster-order pixel job scheduler for the Mandelbrot processor array: hands one
// job per cycle to an idle processor (round-robin) and signals frame completion.
module pixel_job_dispatcher #(
    parameter int unsigned NUM_PROCS = 8,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    parameter int unsigned FIX_W     = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iStart,
    input  logic [FIX_W-1:0]     iX0,
    input  logic [FIX_W-1:0]     iY0,
    input  logic [FIX_W-1:0]     iDx,
    input  logic [FIX_W-1:0]     iDy,
    input  logic [NUM_PROCS-1:0] iProcIdle,
    input  logic                 iPixWritten,
    output logic [NUM_PROCS-1:0] oJobValid,
    output logic [18:0]          oJobAddr,
    output logic [FIX_W-1:0]     oJobCre,
    output logic [FIX_W-1:0]     oJobCim,
    output logic                 oBusy,
    output logic                 oFrameDone
);

    localparam int unsigned TOTAL = H_RES * V_RES;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int unsigned PTR_W = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [FIX_W-1:0]     x0, dx, dy;
    logic [FIX_W-1:0]     cre, cim;
    logic [18:0]          addr;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [CNT_W-1:0]     written_cnt, written_nxt;
    logic [PTR_W-1:0]     rr_ptr, grant_idx;
    logic [NUM_PROCS-1:0] mask_d1, mask_d2, eligible, grant_onehot;
    logic                 grant_found, issue, start_accept, wr_inc, last_pixel;
    int unsigned          cand;

    assign last_pixel  = (x == X_W'(H_RES - 1)) && (y == Y_W'(V_RES - 1));
    assign wr_inc      = iPixWritten && ((state == S_DISPATCH) || (state == S_DRAIN));
    assign written_nxt = written_cnt + CNT_W'(wr_inc);

    // A processor stays masked during its strobe cycle and the two cycles after,
    // covering the window in which its iProcIdle may still be stale.
    assign eligible = iProcIdle & ~(oJobValid | mask_d1 | mask_d2);

    always_comb begin
        grant_found  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        cand         = 0;
        for (int unsigned k = 0; k < NUM_PROCS; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NUM_PROCS)
                cand = cand - NUM_PROCS;
            if (!grant_found && eligible[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
        grant_onehot[grant_idx] = grant_found;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state   = state;
        oBusy        = 1'b0;
        oFrameDone   = 1'b0;
        start_accept = 1'b0;
        issue        = 1'b0;
        case (state)
            S_IDLE: begin
                if (iStart) begin
                    start_accept = 1'b1;
                    next_state   = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                oBusy = 1'b1;
                issue = grant_found;
                if (grant_found && last_pixel)
                    next_state = S_DRAIN;
            end
            S_DRAIN: begin
                oBusy = 1'b1;
                if (written_nxt == CNT_W'(TOTAL))
                    next_state = S_DONE;
            end
            S_DONE: begin
                oFrameDone = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            oJobValid   <= '0;
            oJobAddr    <= '0;
            oJobCre     <= '0;
            oJobCim     <= '0;
            mask_d1     <= '0;
            mask_d2     <= '0;
            rr_ptr      <= '0;
            x0          <= '0;
            dx          <= '0;
            dy          <= '0;
            cre         <= '0;
            cim         <= '0;
            addr        <= '0;
            x           <= '0;
            y           <= '0;
            written_cnt <= '0;
        end else begin
            oJobValid   <= '0;
            mask_d1     <= oJobValid;
            mask_d2     <= mask_d1;
            written_cnt <= written_nxt;
            if (start_accept) begin
                x0          <= iX0;
                dx          <= iDx;
                dy          <= iDy;
                cre         <= iX0;
                cim         <= iY0;
                addr        <= '0;
                x           <= '0;
                y           <= '0;
                written_cnt <= '0;
            end
            if (issue) begin
                oJobValid <= grant_onehot;
                oJobAddr  <= addr;
                oJobCre   <= cre;
                oJobCim   <= cim;
                rr_ptr    <= (grant_idx == PTR_W'(NUM_PROCS - 1)) ? '0 : grant_idx + 1'b1;
                addr      <= addr + 19'd1;
                if (x != X_W'(H_RES - 1)) begin
                    x   <= x + 1'b1;
                    cre <= cre + dx;
                end else begin
                    x   <= '0;
                    y   <= y + 1'b1;
                    cre <= x0;
                    cim <= cim + dy;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_job_dispatcher.sv
// Directed self-checking bench for pixel_job_dispatcher on a 4x2 frame with 4 processors.
module tb_pixel_job_dispatcher;

    localparam int unsigned NP = 4;
    localparam int unsigned HR = 4;
    localparam int unsigned VR = 2;
    localparam int unsigned FW = 27;

    localparam logic [FW-1:0] X0 = 27'h100;
    localparam logic [FW-1:0] Y0 = 27'h200;
    localparam logic [FW-1:0] DX = 27'h10;
    localparam logic [FW-1:0] DY = 27'h7FFFFF8;

    logic          clk = 1'b0;
    logic          reset;
    logic          iStart;
    logic [FW-1:0] iX0, iY0, iDx, iDy;
    logic [NP-1:0] iProcIdle;
    logic          iPixWritten;
    logic [NP-1:0] oJobValid;
    logic [18:0]   oJobAddr;
    logic [FW-1:0] oJobCre, oJobCim;
    logic          oBusy, oFrameDone;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int unsigned cre_tab [8] = '{32'h100, 32'h110, 32'h120, 32'h130,
                                 32'h100, 32'h110, 32'h120, 32'h130};
    int unsigned cim_tab [8] = '{32'h200, 32'h200, 32'h200, 32'h200,
                                 32'h1F8, 32'h1F8, 32'h1F8, 32'h1F8};

    always #5 clk = ~clk;

    pixel_job_dispatcher #(
        .NUM_PROCS(NP),
        .H_RES    (HR),
        .V_RES    (VR),
        .FIX_W    (FW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iStart     (iStart),
        .iX0        (iX0),
        .iY0        (iY0),
        .iDx        (iDx),
        .iDy        (iDy),
        .iProcIdle  (iProcIdle),
        .iPixWritten(iPixWritten),
        .oJobValid  (oJobValid),
        .oJobAddr   (oJobAddr),
        .oJobCre    (oJobCre),
        .oJobCim    (oJobCim),
        .oBusy      (oBusy),
        .oFrameDone (oFrameDone)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 32'(oJobValid), 32'd0);
        check({tag, "_addr"},  32'(oJobAddr),  32'd0);
        check({tag, "_cre"},   32'(oJobCre),   32'd0);
        check({tag, "_cim"},   32'(oJobCim),   32'd0);
        check({tag, "_busy"},  32'(oBusy),     32'd0);
        check({tag, "_done"},  32'(oFrameDone), 32'd0);
    endtask

    initial begin
        int last_c;
        int unsigned jobs;

        reset       = 1'b0;
        iStart      = 1'b0;
        iX0         = X0;
        iY0         = Y0;
        iDx         = DX;
        iDy         = DY;
        iProcIdle   = '1;
        iPixWritten = 1'b0;

        // Reset held with all processors idle, then released without a start
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet("rst");
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_quiet("idle");
        end

        // Raster walk with coordinates; a start pulse mid-frame must be ignored
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        check("start_busy", 32'(oBusy), 32'd1);
        check("start_novalid", 32'(oJobValid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("job%0d_valid", i), 32'(oJobValid), 32'd1 << (i % 4));
            check($sformatf("job%0d_addr", i),  32'(oJobAddr),  32'(i));
            check($sformatf("job%0d_cre", i),   32'(oJobCre),   cre_tab[i]);
            check($sformatf("job%0d_cim", i),   32'(oJobCim),   cim_tab[i]);
            check($sformatf("job%0d_busy", i),  32'(oBusy),     32'd1);
            iStart = (i == 2);
        end
        iStart = 1'b0;
        tick();
        check("drain_novalid", 32'(oJobValid), 32'd0);
        check("drain_busy", 32'(oBusy), 32'd1);

        // Frame completion: 7 writes keep it busy, the 8th produces the done pulse
        iPixWritten = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("wr%0d_busy", k), 32'(oBusy), 32'd1);
            check($sformatf("wr%0d_done", k), 32'(oFrameDone), 32'd0);
            check($sformatf("wr%0d_valid", k), 32'(oJobValid), 32'd0);
        end
        tick();
        iPixWritten = 1'b0;
        check("done_pulse", 32'(oFrameDone), 32'd1);
        check("done_busy", 32'(oBusy), 32'd0);
        tick();
        check("after_done", 32'(oFrameDone), 32'd0);
        check("after_busy", 32'(oBusy), 32'd0);

        // Only processor 2 idle: mask must space its grants
        iProcIdle = 4'b0100;
        iStart    = 1'b1;
        tick();
        iStart = 1'b0;
        check("p2_busy", 32'(oBusy), 32'd1);
        last_c = -100;
        jobs   = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (oJobValid != '0) begin
                check("p2_grant", 32'(oJobValid), 32'h4);
                check("p2_addr", 32'(oJobAddr), jobs);
                if (jobs > 0)
                    check("p2_spacing_ge3", 32'(c - last_c >= 3), 32'd1);
                last_c = c;
                jobs++;
            end
        end
        check("p2_jobs_ge3", 32'(jobs >= 3), 32'd1);

        // Reset mid-frame aborts, then a fresh start begins at pixel 0
        reset = 1'b0;
        tick();
        check_quiet("midrst");
        reset     = 1'b1;
        iProcIdle = '1;
        iStart    = 1'b1;
        tick();
        iStart = 1'b0;
        check("restart_busy", 32'(oBusy), 32'd1);
        tick();
        check("restart_valid", 32'(oJobValid), 32'd1);
        check("restart_addr", 32'(oJobAddr), 32'd0);
        check("restart_cre", 32'(oJobCre), 32'(X0));
        check("restart_cim", 32'(oJobCim), 32'(Y0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
